multicycle_ctrl: RTL and testbench

- Multi-cycle main control FSM for the RV32 subset already decoded by the main opcode decoder: R-type (0110011), load (0000011), store (0100011), branch (1100011).
- Sequences a shared-memory datapath (single ALU, single memory port, IR, ALUOut register) through fetch/decode/execute/memory/writeback.
- Adds a request/ready memory handshake and a wait-timeout trap.
- Sits between the instruction register and the datapath muxes/enables; replaces single-cycle control when instruction and data memory share one port.

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle main control FSM for a shared-memory RV32 datapath
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   opcode              IR[6:0], used in DECODE and ADDR only
//   zero                ALU zero flag, branch taken when 1
//   mem_ready           memory completes the current access this cycle
//   mem_req, mem_we     memory request / write enable
//   i_or_d              address select: 0 = PC, 1 = ALUOut
//   ir_write, pc_write  IR / PC load enables
//   pc_src              PC source: 0 = ALU result, 1 = ALUOut
//   alu_src_a/b, aluop  ALU operand selects and operation class
//   reg_write, mem2reg  register file write and writeback select
//   retire              one-cycle pulse per completed instruction
//   illegal, bus_err    sticky trap causes
//   state               current state code
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       mem2reg,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_LD  = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT - 1 : 0);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             illegal_q, illegal_n;
  logic             bus_err_q, bus_err_n;
  logic             waiting;
  logic             timeout_hit;

  always_comb begin
    state_n   = state_q;
    illegal_n = illegal_q;
    bus_err_n = bus_err_q;

    // A wait cycle is a request cycle the memory did not complete.
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                  && !mem_ready;
    timeout_hit = TMO_EN && waiting && (cnt_q == CNT_LAST);

    case (state_q)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:              state_n = S_EXEC_R;
          OP_LOAD, OP_STORE: state_n = S_ADDR;
          OP_BRANCH:         state_n = S_BRANCH;
          default: begin
            state_n   = S_TRAP;
            illegal_n = 1'b1;
          end
        endcase
      end
      S_ADDR: begin
        // IR is stable here; anything but load/store cannot arrive, trap if it does.
        if (opcode == OP_LOAD)       state_n = S_MEM_RD;
        else if (opcode == OP_STORE) state_n = S_MEM_WR;
        else begin
          state_n   = S_TRAP;
          illegal_n = 1'b1;
        end
      end
      S_MEM_RD: if (mem_ready) state_n = S_WB_LD;
      S_WB_LD:  state_n = S_FETCH;
      S_MEM_WR: if (mem_ready) state_n = S_FETCH;
      S_EXEC_R: state_n = S_WB_R;
      S_WB_R:   state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default: begin
        state_n   = S_TRAP;
        illegal_n = 1'b1;
      end
    endcase

    // mem_ready in the same cycle keeps waiting low, so completion beats the trap.
    if (timeout_hit) begin
      state_n   = S_TRAP;
      bus_err_n = 1'b1;
    end

    cnt_n = (waiting && (state_n == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      illegal_q <= illegal_n;
      bus_err_q <= bus_err_n;
    end
  end

  // Outputs follow the state, qualified by mem_ready/zero where the access or
  // branch outcome decides them; everything is forced low while in reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    aluop     = 2'b00;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    state     = 4'd0;
    if (rst_n) begin
      illegal = illegal_q;
      bus_err = bus_err_q;
      state   = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_WB_LD: begin
          reg_write = 1'b1;
          mem2reg   = 1'b1;
          retire    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = 1'b1;
          retire  = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          aluop     = 2'b10;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          aluop     = 2'b01;
          pc_src    = 1'b1;
          pc_write  = zero;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0010011;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, aluop;
  logic       reg_write, mem2reg, retire, illegal, bus_err;
  logic [3:0] state;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .reg_write(reg_write), .mem2reg(mem2reg), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
  //                   alu_src_a, alu_src_b, aluop, reg_write, mem2reg, retire, illegal, bus_err}
  logic [20:0] obs;
  assign obs = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, aluop, reg_write, mem2reg, retire, illegal, bus_err};

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       z;
    logic [6:0] op;
    logic [3:0] st;
    logic       ill;
    logic       be;
  } stim_t;

  stim_t       stimq[$];
  logic [20:0] sb[$];
  int          checks = 0;
  int          failures = 0;

  // Reference control table for one cycle in a given state.
  function automatic logic [20:0] ev(input logic [3:0] st, input logic rdy, input logic z,
                                     input logic ill, input logic be);
    logic mr, we, iod, irw, pcw, pcs, rw, m2r, ret;
    logic [1:0] asa, asb, aop;
    {mr, we, iod, irw, pcw, pcs, rw, m2r, ret} = '0;
    asa = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1: begin asa = 2'b01; asb = 2'b10; end
      4'd2: begin asa = 2'b10; asb = 2'b10; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; ret = 1; end
      4'd5: begin mr = 1; iod = 1; we = 1; ret = rdy; end
      4'd6: begin asa = 2'b10; aop = 2'b10; end
      4'd7: begin rw = 1; ret = 1; end
      4'd8: begin asa = 2'b10; aop = 2'b01; pcs = 1; pcw = z; ret = 1; end
      default: ;
    endcase
    return {st, mr, we, iod, irw, pcw, pcs, asa, asb, aop, rw, m2r, ret, ill, be};
  endfunction

  task automatic add(input logic rst, input logic rdy, input logic z, input logic [6:0] op,
                     input logic [3:0] st, input logic ill, input logic be);
    stim_t s;
    s.rst = rst; s.rdy = rdy; s.z = z; s.op = op; s.st = st; s.ill = ill; s.be = be;
    stimq.push_back(s);
  endtask

  task automatic apply(input stim_t s);
    rst_n = s.rst; mem_ready = s.rdy; zero = s.z; opcode = s.op;
    sb.push_back(s.rst ? ev(s.st, s.rdy, s.z, s.ill, s.be) : 21'd0);
  endtask

  task automatic test_reset;
    stim_t s; logic [20:0] exp; int n = 0;
    add(0, 1, 1, OP_R, 0, 0, 0);
    add(0, 1, 1, OP_ST, 0, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 1, 0, OP_R, 0, 0, 0);
    add(1, 0, 0, OP_R, 1, 0, 0);
    add(1, 1, 0, OP_R, 6, 0, 0);
    add(1, 1, 0, OP_R, 7, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL rtype cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 1, 0, OP_LD, 0, 0, 0);
    add(1, 1, 0, OP_LD, 1, 0, 0);
    add(1, 0, 0, OP_LD, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, OP_LD, 3, 0, 0);
    add(1, 1, 0, OP_LD, 3, 0, 0);
    add(1, 0, 0, OP_LD, 4, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL load_wait cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    stim_t s; logic [20:0] exp; int n = 0;
    for (int k = 1; k >= 0; k--) begin
      add(1, 1, k[0], OP_BR, 0, 0, 0);
      add(1, 1, k[0], OP_BR, 1, 0, 0);
      add(1, 1, k[0], OP_BR, 8, 0, 0);
    end
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL branch cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_store_back_to_back;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 0, 0, OP_ST, 0, 0, 0);
    add(1, 0, 0, OP_ST, 0, 0, 0);
    add(1, 1, 0, OP_ST, 0, 0, 0);
    add(1, 1, 0, OP_ST, 1, 0, 0);
    add(1, 0, 0, OP_ST, 2, 0, 0);
    add(1, 1, 0, OP_ST, 5, 0, 0);
    // Second store: ready arrives on the last allowed wait cycle.
    add(1, 1, 0, OP_ST, 0, 0, 0);
    add(1, 1, 0, OP_ST, 1, 0, 0);
    add(1, 1, 0, OP_ST, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, OP_ST, 5, 0, 0);
    add(1, 1, 0, OP_ST, 5, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL store cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 1, 0, OP_BAD, 0, 0, 0);
    add(1, 1, 0, OP_BAD, 1, 0, 0);
    for (int i = 0; i < 20; i++) add(1, i[0], i[1], OP_R, 9, 1, 0);
    add(0, 1, 0, OP_R, 0, 0, 0);
    add(1, 1, 0, OP_R, 0, 0, 0);
    add(1, 1, 0, OP_R, 1, 0, 0);
    add(1, 1, 0, OP_R, 6, 0, 0);
    add(1, 1, 0, OP_R, 7, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL illegal cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 1, 0, OP_ST, 0, 0, 0);
    add(1, 1, 0, OP_ST, 1, 0, 0);
    add(1, 1, 0, OP_ST, 2, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, OP_ST, 5, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, OP_ST, 9, 0, 1);
    add(0, 0, 0, OP_R, 0, 0, 0);
    add(1, 1, 0, OP_R, 0, 0, 0);
    add(1, 1, 0, OP_R, 1, 0, 0);
    add(1, 1, 0, OP_R, 6, 0, 0);
    add(1, 1, 0, OP_R, 7, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait;
    stim_t s; logic [20:0] exp; int n = 0;
    add(1, 1, 0, OP_LD, 0, 0, 0);
    add(1, 1, 0, OP_LD, 1, 0, 0);
    add(1, 1, 0, OP_LD, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, OP_LD, 3, 0, 0);
    add(0, 0, 0, OP_LD, 0, 0, 0);
    // A full set of wait cycles after reset only fits if the counter was cleared.
    for (int i = 0; i < 3; i++) add(1, 0, 0, OP_LD, 0, 0, 0);
    add(1, 1, 0, OP_LD, 0, 0, 0);
    add(1, 1, 0, OP_LD, 1, 0, 0);
    add(1, 1, 0, OP_LD, 2, 0, 0);
    add(1, 1, 0, OP_LD, 3, 0, 0);
    add(1, 1, 0, OP_LD, 4, 0, 0);
    while (stimq.size() > 0) begin
      s = stimq.pop_front(); apply(s);
      @(negedge clk);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_mid_wait cyc%0d got=%h exp=%h", n, obs, exp); end
      n++; @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
    @(posedge clk); #1;
    test_reset;
    test_rtype;
    test_load_wait;
    test_branch;
    test_store_back_to_back;
    test_illegal;
    test_timeout;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
